csr_sys_seq: RTL and testbench

- Multi-cycle sequencer for system instructions leaving execute.
- Consumes the 5-bit SYSOP cause code and 64-bit tval from the execute-stage decode, plus pc and rs1/zimm operand.
- Drives the single-ported CSR file (1 read port, 1 write port) through the read-modify-write, trap-entry (mepc/mcause/mtval/mtvec) and mret sequences.
- Holds the pipeline with a ready/valid handshake and issues a redirect.

---
 rtl/csr_seq_pkg.sv | 45 ++++
 rtl/csr_rmw_alu.sv | 37 +++
 rtl/csr_sys_seq.sv | 204 ++++++++++++++++++++
 tb/tb_csr_sys_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_seq_pkg.sv
// Shared definitions for the system-instruction sequencer: SYSOP cause codes,
// machine CSR addresses, mcause values and the sequencer state encoding.
// Purpose: constants/types only. Latency: n/a. Backpressure: n/a.
package csr_seq_pkg;

  // SYSOP cause codes from the execute-stage decode
  localparam logic [4:0] SYSOP_NONE   = 5'd0;
  localparam logic [4:0] SYSOP_ECALL  = 5'd1;
  localparam logic [4:0] SYSOP_EBREAK = 5'd2;
  localparam logic [4:0] SYSOP_RET    = 5'd3;
  localparam logic [4:0] SYSOP_CSR_W  = 5'd4;
  localparam logic [4:0] SYSOP_CSR_S  = 5'd5;
  localparam logic [4:0] SYSOP_CSR_C  = 5'd6;

  // Machine-mode CSR addresses touched by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // mcause exception codes
  localparam logic [63:0] MCAUSE_ILLEGAL_INSN = 64'd2;
  localparam logic [63:0] MCAUSE_BREAKPOINT   = 64'd3;
  localparam logic [63:0] MCAUSE_ECALL_M      = 64'd11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CSR_RD,
    ST_CSR_WR,
    ST_TRAP_EPC,
    ST_TRAP_CAUSE,
    ST_TRAP_TVAL,
    ST_VEC_RD,
    ST_VEC_WAIT,
    ST_RET_RD,
    ST_RET_WAIT,
    ST_FIN
  } seq_state_e;

  function automatic logic is_csr_op(input logic [4:0] op);
    return (op == SYSOP_CSR_W) || (op == SYSOP_CSR_S) || (op == SYSOP_CSR_C);
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write datapath for CSR ops: new value and write enable from op/old/src.
// Latency: combinational. Backpressure: none.
// Ports: i_op (SYSOP code), i_old (current CSR value), i_src (rs1/zimm),
//        o_new (value to write), o_we (write needed; set/clear with zero src skip it).
module csr_rmw_alu
  import csr_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  output logic [XLEN-1:0] o_new,
  output logic            o_we
);

  always_comb begin
    o_new = i_old;
    o_we  = 1'b0;
    case (i_op)
      SYSOP_CSR_W: begin
        o_new = i_src;
        o_we  = 1'b1;
      end
      SYSOP_CSR_S: begin
        o_new = i_old | i_src;
        o_we  = |i_src;
      end
      SYSOP_CSR_C: begin
        o_new = i_old & ~i_src;
        o_we  = |i_src;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_sys_seq.sv
// Multi-cycle sequencer for system ops: CSR read-modify-write, trap entry, mret.
// Latency: CSR op / mret 3 cycles accept->done, trap entry 6 cycles; unknown op err next cycle.
// Backpressure: req_ready high only in IDLE; one op in flight, next accept the cycle after done.
// Ports: req_* (op in, valid/ready), csr_re/raddr/rdata (read port, 1-cycle data),
//        csr_we/waddr/wdata (write port), rd_we/rd_wdata (old CSR value writeback),
//        redirect_valid/pc (pc redirect pulse), done/err (completion / unknown-op pulses).
// Optional: define CSR_SEQ_RO_TRAP_EN to turn writes to read-only CSRs into an
// illegal-instruction trap instead of issuing them.
module csr_sys_seq
  import csr_seq_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_cause,
  input  logic [XLEN-1:0]   req_tval,
  input  logic [XLEN-1:0]   req_pc,
  input  logic [XLEN-1:0]   req_src,
  output logic              csr_re,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              done,
  output logic              err
);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic [4:0]        r_cause;
  logic [XLEN-1:0]   r_tval;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_src;
  logic [XLEN-1:0]   r_mcause;
  logic [XLEN-1:0]   r_mtval;
  logic              r_err;

  logic              w_accept;
  logic [CSR_AW-1:0] w_addr;
  logic [XLEN-1:0]   w_new;
  logic              w_alu_we;
  logic              w_ro_trap;
  logic              w_unused;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_addr   = r_tval[CSR_AW-1:0];
  // Only the CSR address field of tval is consumed.
  assign w_unused = ^r_tval[XLEN-1:CSR_AW];

  csr_rmw_alu #(.XLEN(XLEN)) u_alu (
    .i_op  (r_cause),
    .i_old (csr_rdata),
    .i_src (r_src),
    .o_new (w_new),
    .o_we  (w_alu_we)
  );

`ifdef CSR_SEQ_RO_TRAP_EN
  // Top two address bits 2'b11 mark a read-only CSR; only a real write traps.
  assign w_ro_trap = (w_addr[CSR_AW-1:CSR_AW-2] == 2'b11) && w_alu_we;
`else
  assign w_ro_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Operand latches and trap payload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause  <= SYSOP_NONE;
      r_tval   <= '0;
      r_pc     <= '0;
      r_src    <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept && (req_cause > SYSOP_CSR_C);
      if (w_accept) begin
        r_cause <= req_cause;
        r_tval  <= req_tval;
        r_pc    <= req_pc;
        r_src   <= req_src;
        if (req_cause == SYSOP_EBREAK) begin
          r_mcause <= XLEN'(MCAUSE_BREAKPOINT);
          r_mtval  <= req_pc;
        end else begin
          r_mcause <= XLEN'(MCAUSE_ECALL_M);
          r_mtval  <= '0;
        end
      end else if (r_state == ST_CSR_WR && w_ro_trap) begin
        r_mcause <= XLEN'(MCAUSE_ILLEGAL_INSN);
        r_mtval  <= XLEN'(w_addr);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_cause == SYSOP_ECALL || req_cause == SYSOP_EBREAK) w_next = ST_TRAP_EPC;
          else if (req_cause == SYSOP_RET)                          w_next = ST_RET_RD;
          else if (is_csr_op(req_cause))                            w_next = ST_CSR_RD;
          else                                                      w_next = ST_IDLE;
        end
      end
      ST_CSR_RD:     w_next = ST_CSR_WR;
      ST_CSR_WR:     w_next = w_ro_trap ? ST_TRAP_EPC : ST_FIN;
      ST_TRAP_EPC:   w_next = ST_TRAP_CAUSE;
      ST_TRAP_CAUSE: w_next = ST_TRAP_TVAL;
      ST_TRAP_TVAL:  w_next = ST_VEC_RD;
      ST_VEC_RD:     w_next = ST_VEC_WAIT;
      ST_VEC_WAIT:   w_next = ST_FIN;
      ST_RET_RD:     w_next = ST_RET_WAIT;
      ST_RET_WAIT:   w_next = ST_FIN;
      ST_FIN:        w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // Outputs: purely state-decoded, so each state owns at most one CSR port.
  always_comb begin
    req_ready      = 1'b0;
    csr_re         = 1'b0;
    csr_raddr      = '0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    rd_we          = 1'b0;
    rd_wdata       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    done           = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_CSR_RD: begin
        csr_re    = 1'b1;
        csr_raddr = w_addr;
      end
      ST_CSR_WR: begin
        // A trapping write leaves both the CSR and rd untouched.
        if (!w_ro_trap) begin
          rd_we     = 1'b1;
          rd_wdata  = csr_rdata;
          csr_we    = w_alu_we;
          csr_waddr = w_alu_we ? w_addr : '0;
          csr_wdata = w_alu_we ? w_new : '0;
        end
      end
      ST_TRAP_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_AW'(CSR_MEPC);
        csr_wdata = r_pc;
      end
      ST_TRAP_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_AW'(CSR_MCAUSE);
        csr_wdata = r_mcause;
      end
      ST_TRAP_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_AW'(CSR_MTVAL);
        csr_wdata = r_mtval;
      end
      ST_VEC_RD: begin
        csr_re    = 1'b1;
        csr_raddr = CSR_AW'(CSR_MTVEC);
      end
      ST_VEC_WAIT: begin
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
      end
      ST_RET_RD: begin
        csr_re    = 1'b1;
        csr_raddr = CSR_AW'(CSR_MEPC);
      end
      ST_RET_WAIT: begin
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[XLEN-1:1], 1'b0};
      end
      ST_FIN: done = 1'b1;
      default: ;
    endcase
  end

  assign err = r_err;

endmodule

// File: tb/tb_csr_sys_seq.sv
// Randomized self-checking bench for csr_sys_seq with a behavioural CSR model.
module tb_csr_sys_seq;
  import csr_seq_pkg::*;

  localparam int XLEN = 64;
  localparam int AW   = 12;
`ifdef CSR_SEQ_RO_TRAP_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_cause;
  logic [XLEN-1:0] req_tval, req_pc, req_src;
  logic            csr_re, csr_we, rd_we, redirect_valid, done, err;
  logic [AW-1:0]   csr_raddr, csr_waddr;
  logic [XLEN-1:0] csr_rdata, csr_wdata, rd_wdata, redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_sys_seq #(.XLEN(XLEN), .CSR_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cause(req_cause),
    .req_tval(req_tval), .req_pc(req_pc), .req_src(req_src),
    .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rd_we(rd_we), .rd_wdata(rd_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // CSR addresses the bench uses; anything else lands in slot 7.
  function automatic int slot(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h340: return 2;
      12'h341: return 3;
      12'h342: return 4;
      12'h343: return 5;
      12'hC00: return 6;
      default: return 7;
    endcase
  endfunction

  // Environment CSR file: one-cycle read latency.
  logic [63:0] env_mem [0:7];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) env_mem[i] <= '0;
      csr_rdata <= '0;
    end else begin
      if (csr_re) csr_rdata <= env_mem[slot(csr_raddr)];
      if (csr_we) env_mem[slot(csr_waddr)] <= csr_wdata;
    end
  end

  // Reference model state and expected write list.
  logic [63:0] ref_mem [0:7];
  logic [11:0] ew_a[$];
  logic [63:0] ew_d[$];

  task automatic ref_wr(input logic [11:0] a, input logic [63:0] d);
    ew_a.push_back(a);
    ew_d.push_back(d);
    ref_mem[slot(a)] = d;
  endtask

  task automatic run_op(input string nm, input logic [4:0] c, input logic [63:0] tv,
                        input logic [63:0] pc, input logic [63:0] src);
    logic [11:0] a;
    logic [63:0] old, nv, tcause, ttval, exp_rdv, exp_rpc, rdv, rpc;
    bit we, trap;
    int exp_lat, exp_rd, exp_redir, exp_err;
    int lat, n_rd, n_redir, n_err, n_excl, nw;
    logic [11:0] ow_a[$];
    logic [63:0] ow_d[$];

    // ---- model ----
    ew_a.delete(); ew_d.delete();
    a = tv[11:0];
    exp_lat = 0; exp_rd = 0; exp_redir = 0; exp_err = 0;
    exp_rdv = '0; exp_rpc = '0; trap = 1'b0; tcause = '0; ttval = '0;
    if (c == SYSOP_CSR_W || c == SYSOP_CSR_S || c == SYSOP_CSR_C) begin
      old = ref_mem[slot(a)];
      if (c == SYSOP_CSR_W)      begin nv = src;         we = 1'b1;        end
      else if (c == SYSOP_CSR_S) begin nv = old | src;   we = (src != 0);  end
      else                       begin nv = old & ~src;  we = (src != 0);  end
      if (RO_EN && a[11:10] == 2'b11 && we) begin
        trap = 1'b1; tcause = 64'd2; ttval = {52'd0, a}; exp_lat = 3;
      end else begin
        exp_rd = 1; exp_rdv = old; exp_lat = 3;
        if (we) ref_wr(a, nv);
      end
    end else if (c == SYSOP_ECALL) begin
      trap = 1'b1; tcause = 64'd11; ttval = '0; exp_lat = 1;
    end else if (c == SYSOP_EBREAK) begin
      trap = 1'b1; tcause = 64'd3; ttval = pc; exp_lat = 1;
    end else if (c == SYSOP_RET) begin
      exp_redir = 1; exp_rpc = ref_mem[slot(12'h341)] & ~64'h1; exp_lat = 3;
    end else if (c != SYSOP_NONE) begin
      exp_err = 1;
    end
    if (trap) begin
      // Trap entry: mepc, mcause, mtval writes, mtvec read, redirect -> five extra cycles.
      ref_wr(12'h341, pc);
      ref_wr(12'h342, tcause);
      ref_wr(12'h343, ttval);
      exp_redir = 1;
      exp_rpc   = ref_mem[slot(12'h305)] & ~64'h3;
      exp_lat   = exp_lat + 5;
    end

    // ---- drive ----
    @(negedge clk);
    chk({nm, ":ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_cause = c; req_tval = tv; req_pc = pc; req_src = src;
    @(negedge clk);
    req_valid = 1'b0;
    req_cause = $urandom_range(0, 31); req_tval = {$urandom, $urandom};
    req_pc = {$urandom, $urandom}; req_src = {$urandom, $urandom};

    // ---- observe (bounded) ----
    lat = 0; n_rd = 0; n_redir = 0; n_err = 0; n_excl = 0; rdv = '0; rpc = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (csr_we) begin ow_a.push_back(csr_waddr); ow_d.push_back(csr_wdata); end
      if (csr_re && csr_we) n_excl++;
      if (rd_we) begin n_rd++; rdv = rd_wdata; end
      if (redirect_valid) begin n_redir++; rpc = redirect_pc; end
      if (err) n_err++;
      if (done) begin lat = k; break; end
    end

    chk({nm, ":latency"}, lat, exp_lat);
    chk({nm, ":nwrites"}, ow_a.size(), ew_a.size());
    nw = (ow_a.size() < ew_a.size()) ? ow_a.size() : ew_a.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s:waddr%0d", nm, i), ow_a[i], ew_a[i]);
      chk($sformatf("%s:wdata%0d", nm, i), ow_d[i], ew_d[i]);
    end
    chk({nm, ":rd_we_cnt"}, n_rd, exp_rd);
    if (exp_rd != 0) chk({nm, ":rd_wdata"}, rdv, exp_rdv);
    chk({nm, ":redir_cnt"}, n_redir, exp_redir);
    if (exp_redir != 0) chk({nm, ":redir_pc"}, rpc, exp_rpc);
    chk({nm, ":err_cnt"}, n_err, exp_err);
    chk({nm, ":re_we_excl"}, n_excl, 0);
  endtask

  logic [11:0] addr_list [0:6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hC00};

  initial begin
    logic [4:0]  c;
    logic [63:0] tv, src;
    int nw_after, n_misc;

    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_cause = '0;
    req_tval = '0; req_pc = '0; req_src = '0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("rst:req_ready", req_ready, 1'b1);
    chk("rst:csr_re", csr_re, 1'b0);
    chk("rst:csr_we", csr_we, 1'b0);
    chk("rst:rd_we", rd_we, 1'b0);
    chk("rst:redirect", redirect_valid, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:err", err, 1'b0);
    chk("rst:csr_wdata", csr_wdata, 64'h0);

    // Directed scenarios
    run_op("w300",   SYSOP_CSR_W,  64'h300, 64'h0, 64'h1);
    run_op("s300",   SYSOP_CSR_S,  64'h300, 64'h0, 64'h8);        // old 1 -> 9
    run_op("c0",     SYSOP_CSR_C,  64'h300, 64'h0, 64'h0);        // rd only, no write
    run_op("c300",   SYSOP_CSR_C,  64'h300, 64'h0, 64'h1);        // 9 -> 8
    run_op("wtvec",  SYSOP_CSR_W,  64'h305, 64'h0, 64'h8000_0101);
    run_op("ecall",  SYSOP_ECALL,  64'h0, 64'h8000_0010, 64'h0);  // redirect 0x8000_0100
    run_op("wepc",   SYSOP_CSR_W,  64'h341, 64'h0, 64'h8000_0013);
    run_op("ret",    SYSOP_RET,    64'h0, 64'h0, 64'h0);          // redirect 0x8000_0012
    run_op("ebreak", SYSOP_EBREAK, 64'h0, 64'h1234_5678_9ABC_DEF2, 64'h0);
    run_op("none",   SYSOP_NONE,   64'h300, 64'h0, 64'hFF);
    run_op("unk7",   5'd7,         64'h300, 64'h0, 64'hFF);
    run_op("unk31",  5'd31,        64'h305, 64'h0, 64'hFF);
    run_op("ro_w",   SYSOP_CSR_W,  64'hC00, 64'h40, 64'h55);
    run_op("ro_s0",  SYSOP_CSR_S,  64'hC00, 64'h44, 64'h0);

    // Reset during TRAP_CAUSE: mepc and mcause land, mtval never does.
    @(negedge clk);
    req_valid = 1'b1; req_cause = SYSOP_ECALL; req_pc = 64'hABCD_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid:epc_we", csr_we, 1'b1);
    chk("rstmid:epc_addr", csr_waddr, 12'h341);
    @(negedge clk);
    chk("rstmid:cause_addr", csr_waddr, 12'h342);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_mem[slot(12'h341)] = 64'hABCD_0040;
    ref_mem[slot(12'h342)] = 64'd11;
    chk("rstmid:ready", req_ready, 1'b1);
    chk("rstmid:we", csr_we, 1'b0);
    nw_after = 0; n_misc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (csr_we) nw_after++;
      if (done || redirect_valid || err || csr_re) n_misc++;
    end
    chk("rstmid:late_writes", nw_after, 0);
    chk("rstmid:late_activity", n_misc, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) c = 5'($urandom_range(7, 31));
      else                           c = 5'($urandom_range(0, 6));
      tv  = {$urandom, 20'($urandom), addr_list[$urandom_range(0, 6)]};
      src = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      run_op($sformatf("rnd%0d", n), c, tv, {$urandom, $urandom}, src);
    end

    // Final CSR file contents versus model
    @(negedge clk);
    for (int i = 0; i < 7; i++)
      chk($sformatf("mem_%h", addr_list[i]), env_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
